// File: rtl/mux_sel_pipe.sv
// Registered N-to-1 select mux behind a valid/ready handshake with a 2-entry skid buffer.
// Optional macro MUX_SEL_PIPE_ERRCNT_EN adds a saturating out-of-range select counter on err_cnt_o.
module mux_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    sel_err_o
`ifdef MUX_SEL_PIPE_ERRCNT_EN
    ,
    output logic [15:0]             err_cnt_o
`endif
);

    generate
        if (NUM_IN < 2 || NUM_IN > (1 << SEL_W)) begin : gCfgCheck
            $error("mux_sel_pipe: NUM_IN must be in 2..2**SEL_W");
        end
    endgenerate

    logic [WIDTH-1:0] selData;
    logic             selInRange;
    logic             accept;

    logic [WIDTH-1:0] dataOut_q,   dataOut_d;
    logic             validOut_q,  validOut_d;
    logic [WIDTH-1:0] skidData_q,  skidData_d;
    logic             skidValid_q, skidValid_d;
    logic             ready_q,     ready_d;
    logic             selErr_q,    selErr_d;
`ifdef MUX_SEL_PIPE_ERRCNT_EN
    logic [15:0]      errCnt_q,    errCnt_d;
`endif

    // Unused select codes fall back to channel 0 and raise the error path.
    always_comb begin
        selData    = data_i[WIDTH-1:0];
        selInRange = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (select_i == SEL_W'(k)) begin
                selData    = data_i[k*WIDTH +: WIDTH];
                selInRange = 1'b1;
            end
        end
    end

    assign accept = valid_i & ready_q;

    always_comb begin
        dataOut_d   = dataOut_q;
        validOut_d  = validOut_q;
        skidData_d  = skidData_q;
        skidValid_d = skidValid_q;
        selErr_d    = selErr_q;
`ifdef MUX_SEL_PIPE_ERRCNT_EN
        errCnt_d    = errCnt_q;
`endif
        // Skid always drains before a newer beat; ready_q is low while it is full.
        if (!validOut_q || ready_i) begin
            if (skidValid_q) begin
                dataOut_d   = skidData_q;
                validOut_d  = 1'b1;
                skidValid_d = 1'b0;
            end else if (accept) begin
                dataOut_d  = selData;
                validOut_d = 1'b1;
            end else begin
                validOut_d = 1'b0;
            end
        end else if (accept) begin
            skidData_d  = selData;
            skidValid_d = 1'b1;
        end
        ready_d = ~skidValid_d;
        if (accept && !selInRange) begin
            selErr_d = 1'b1;
`ifdef MUX_SEL_PIPE_ERRCNT_EN
            if (errCnt_q != 16'hFFFF) begin
                errCnt_d = errCnt_q + 16'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dataOut_q   <= '0;
            validOut_q  <= 1'b0;
            skidData_q  <= '0;
            skidValid_q <= 1'b0;
            ready_q     <= 1'b1;
            selErr_q    <= 1'b0;
`ifdef MUX_SEL_PIPE_ERRCNT_EN
            errCnt_q    <= 16'd0;
`endif
        end else begin
            dataOut_q   <= dataOut_d;
            validOut_q  <= validOut_d;
            skidData_q  <= skidData_d;
            skidValid_q <= skidValid_d;
            ready_q     <= ready_d;
            selErr_q    <= selErr_d;
`ifdef MUX_SEL_PIPE_ERRCNT_EN
            errCnt_q    <= errCnt_d;
`endif
        end
    end

    assign data_o    = dataOut_q;
    assign valid_o   = validOut_q;
    assign ready_o   = ready_q;
    assign sel_err_o = selErr_q;
`ifdef MUX_SEL_PIPE_ERRCNT_EN
    assign err_cnt_o = errCnt_q;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Self-checking bench for mux_sel_pipe: vector table, hand sequences and random traffic vs a queue model.
module tb_mux_sel_pipe;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NUM_IN*WIDTH-1:0] data_i;
    logic [SEL_W-1:0]        select_i;
    logic                    valid_i;
    logic                    ready_o;
    logic [WIDTH-1:0]        data_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    sel_err_o;
`ifdef MUX_SEL_PIPE_ERRCNT_EN
    logic [15:0]             err_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    mux_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .select_i  (select_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sel_err_o (sel_err_o)
`ifdef MUX_SEL_PIPE_ERRCNT_EN
        ,
        .err_cnt_o (err_cnt_o)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the block is a 2-deep in-order FIFO whose head is data_o.
    logic [WIDTH-1:0] modelQ[$];
    logic [WIDTH-1:0] modelLast;
    logic             modelErr;
    int               modelErrCnt;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic             valid;
        logic             rdy;
        logic [WIDTH-1:0] expData;
        logic             expValid;
        logic             expReady;
        logic             expErr;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [SEL_W-1:0] sel, input logic v,
                                 input logic r, input logic [NUM_IN*WIDTH-1:0] data);
        logic             readyM;
        logic [WIDTH-1:0] beat;
        int               selIdx;
        @(negedge clk_i);
        rst_i    = rst;
        select_i = sel;
        valid_i  = v;
        ready_i  = r;
        data_i   = data;
        @(posedge clk_i);
        if (rst) begin
            modelQ      = {};
            modelLast   = '0;
            modelErr    = 1'b0;
            modelErrCnt = 0;
        end else begin
            readyM = (modelQ.size() < 2);
            if (modelQ.size() > 0 && r) void'(modelQ.pop_front());
            if (v && readyM) begin
                selIdx = int'(sel);
                if (selIdx >= NUM_IN) begin
                    selIdx   = 0;
                    modelErr = 1'b1;
                    if (modelErrCnt < 65535) modelErrCnt++;
                end
                beat = data[selIdx*WIDTH +: WIDTH];
                modelQ.push_back(beat);
            end
            if (modelQ.size() > 0) modelLast = modelQ[0];
        end
        #1;
        checkOutput("model_valid", 32'(valid_o), 32'(modelQ.size() > 0));
        checkOutput("model_ready", 32'(ready_o), 32'(modelQ.size() < 2));
        checkOutput("model_data", data_o, modelLast);
        checkOutput("model_err", 32'(sel_err_o), 32'(modelErr));
`ifdef MUX_SEL_PIPE_ERRCNT_EN
        checkOutput("model_errcnt", 32'(err_cnt_o), 32'(modelErrCnt));
`endif
    endtask

    initial begin
        logic [NUM_IN*WIDTH-1:0] chans;
        logic [NUM_IN*WIDTH-1:0] rnd;
        logic                    rstR;

        rst_i = 1'b1; select_i = '0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        modelQ = {}; modelLast = '0; modelErr = 1'b0; modelErrCnt = 0;
        chans = {32'h33333333, 32'h22222222, 32'h11111111};

        vecs[0] = '{sel: 2'd0, valid: 1'b1, rdy: 1'b1, expData: 32'h11111111, expValid: 1'b1, expReady: 1'b1, expErr: 1'b0};
        vecs[1] = '{sel: 2'd1, valid: 1'b1, rdy: 1'b1, expData: 32'h22222222, expValid: 1'b1, expReady: 1'b1, expErr: 1'b0};
        vecs[2] = '{sel: 2'd2, valid: 1'b1, rdy: 1'b1, expData: 32'h33333333, expValid: 1'b1, expReady: 1'b1, expErr: 1'b0};
        vecs[3] = '{sel: 2'd3, valid: 1'b1, rdy: 1'b1, expData: 32'h11111111, expValid: 1'b1, expReady: 1'b1, expErr: 1'b1};
        vecs[4] = '{sel: 2'd2, valid: 1'b0, rdy: 1'b1, expData: 32'h11111111, expValid: 1'b0, expReady: 1'b1, expErr: 1'b1};
        vecs[5] = '{sel: 2'd1, valid: 1'b1, rdy: 1'b1, expData: 32'h22222222, expValid: 1'b1, expReady: 1'b1, expErr: 1'b1};

        $display("[TB] reset");
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, '0);
        checkOutput("rst_data", data_o, 32'h0);
        checkOutput("rst_valid", 32'(valid_o), 32'h0);
        checkOutput("rst_ready", 32'(ready_o), 32'h1);
        checkOutput("rst_err", 32'(sel_err_o), 32'h0);

        $display("[TB] select sweep and out-of-range");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, vecs[i].sel, vecs[i].valid, vecs[i].rdy, chans);
            checkOutput("vec_data", data_o, vecs[i].expData);
            checkOutput("vec_valid", 32'(valid_o), 32'(vecs[i].expValid));
            checkOutput("vec_ready", 32'(ready_o), 32'(vecs[i].expReady));
            checkOutput("vec_err", 32'(sel_err_o), 32'(vecs[i].expErr));
        end
`ifdef MUX_SEL_PIPE_ERRCNT_EN
        checkOutput("vec_errcnt", 32'(err_cnt_o), 32'h1);
`endif

        $display("[TB] backpressure");
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, chans);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, {64'h0, 32'hAAAA0001});
        checkOutput("bp_a_loaded", data_o, 32'hAAAA0001);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, {64'h0, 32'hBBBB0002});
        checkOutput("bp_a_held", data_o, 32'hAAAA0001);
        checkOutput("bp_ready_low", 32'(ready_o), 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, {64'h0, 32'hCCCC0003});
        checkOutput("bp_a_stable", data_o, 32'hAAAA0001);
        checkOutput("bp_valid_stable", 32'(valid_o), 32'h1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, {64'h0, 32'hCCCC0003});
        checkOutput("bp_b_out", data_o, 32'hBBBB0002);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, {64'h0, 32'hCCCC0003});
        checkOutput("bp_c_out", data_o, 32'hCCCC0003);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, chans);
        checkOutput("bp_drained", 32'(valid_o), 32'h0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 2'd1, 1'b1, 1'b0, chans);
        applyStimulus(1'b0, 2'd2, 1'b1, 1'b0, chans);
        checkOutput("mid_full", 32'(ready_o), 32'h0);
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b1, chans);
        checkOutput("mid_valid", 32'(valid_o), 32'h0);
        checkOutput("mid_ready", 32'(ready_o), 32'h1);
        checkOutput("mid_data", data_o, 32'h0);
        checkOutput("mid_err", 32'(sel_err_o), 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b1, 1'b1, chans);
        checkOutput("mid_flow", data_o, 32'h33333333);

`ifdef MUX_SEL_PIPE_ERRCNT_EN
        $display("[TB] counter saturation");
        @(negedge clk_i);
        force dut.errCnt_q = 16'hFFFE;
        #1;
        release dut.errCnt_q;
        modelErrCnt = 65534;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd3, 1'b1, 1'b1, chans);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, chans);
        checkOutput("sat_cnt", 32'(err_cnt_o), 32'h0000FFFF);
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            rnd  = {$urandom(), $urandom(), $urandom()};
            rstR = ($urandom_range(0, 79) == 0);
            applyStimulus(rstR, SEL_W'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) != 0), rnd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised, registered N-to-1 operand/forwarding multiplexer. It is the pipelined successor of the combinational 3-input select mux.
- Selects one of NUM_IN packed WIDTH-bit inputs by binary select.
- Registers the result behind a valid/ready handshake, with a 2-entry skid buffer so upstream and downstream can stall independently.
- Used between pipeline stages of each core where the select path is timing-critical.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_IN, 3, number of input channels; must be 2..2^SEL_W.
- SEL_W, 2, select width in bits.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- data_i  input  NUM_IN*WIDTH  packed channels; channel k = data_i[k*WIDTH +: WIDTH].
- select_i  input  SEL_W  binary channel select, sampled with the beat.
- valid_i  input  1  upstream beat valid.
- ready_o  output  1  block can accept a beat this cycle.
- data_o  output  WIDTH  registered selected data.
- valid_o  output  1  data_o holds a valid beat.
- ready_i  input  1  downstream accepts data_o this cycle.
- sel_err_o  output  1  sticky flag: an accepted beat had select_i >= NUM_IN.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Outputs: data_o=0, valid_o=0, ready_o=1, sel_err_o=0.
  - Skid buffer emptied.
  - Overrides every other event in the same cycle, including beats mid-transfer; those beats are dropped.
- Select rule:
  - sel_data = channel[select_i] when select_i < NUM_IN.
  - Otherwise sel_data = channel 0, and sel_err_o is set on acceptance.
  - select_i is ignored when the beat is not accepted.
- Acceptance: accept = valid_i & ready_o. Output transfer: xfer = valid_o & ready_i.
- ready_o is a register; it equals NOT skid_valid, so it has no combinational path from ready_i.
- Output register load condition: (!valid_o | ready_i).
  - If skid_valid: data_o <= skid_data, valid_o <= 1, skid_valid <= 0.
  - Else if accept: data_o <= sel_data, valid_o <= 1.
  - Else: valid_o <= 0 (data_o holds its value).
- Output register not loadable (valid_o & !ready_i) and accept: skid_data <= sel_data, skid_valid <= 1, so ready_o falls the next cycle.
- Simultaneous skid drain and new accept: impossible, because ready_o=0 whenever skid_valid=1.
- Latency: 1 cycle from accept to valid_o when unstalled.
- Throughput: 1 beat/cycle with ready_i held high.
- Ordering: beats are strictly in order. Skid contents always leave before any newer beat.
- data_o and valid_o must not change while valid_o & !ready_i (held stable under stall).
- sel_err_o clears only on reset.
- Maximum occupancy: 2 beats (output register + skid). No beat is lost or duplicated.
- NUM_IN < 2^SEL_W is legal; unused codes take the error path. NUM_IN > 2^SEL_W is a configuration error and must be caught by an elaboration-time check.

Optional Feature:
- Macro: MUX_SEL_PIPE_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt_o [15:0]: count of accepted beats with select_i >= NUM_IN.
  - Increments by 1 at acceptance and saturates at 16'hFFFF.
  - Reset to 0 by rst_i.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles, then 0 -> data_o=0, valid_o=0, ready_o=1, sel_err_o=0 on the first cycle after reset.
- Select sweep (WIDTH=32, NUM_IN=3): channels 0..2 = 32'h11111111, 32'h22222222, 32'h33333333; ready_i=1; select_i=0,1,2 on consecutive cycles -> data_o=32'h11111111, 32'h22222222, 32'h33333333 on the 3 following cycles, valid_o=1 throughout, sel_err_o=0.
- Out-of-range: select_i=3 with a valid beat -> data_o=32'h11111111 next cycle, sel_err_o=1 and staying 1. With MUX_SEL_PIPE_ERRCNT_EN, err_cnt_o=1.
- Backpressure: ready_i=0 while 3 beats (A,B,C) are offered back-to-back ->
  - A is held in data_o and B goes to the skid; ready_o=0 from the cycle after B; C is not accepted.
  - Raise ready_i -> output order A, B, C; data_o stable while stalled; no loss or duplicate.
- Reset mid-operation: output register and skid both full, assert rst_i -> next cycle valid_o=0, ready_o=1, data_o=0; subsequent beats flow normally.
- Counter saturation (feature on): force the counter to 16'hFFFE, then send 3 out-of-range beats -> err_cnt_o=16'hFFFF and holds.
